// File: rtl/coin_bank.sv
// coin_bank: coin-slot credit accumulator with ceiling reject, vend handshake and refund.
// Build option: define COIN_BANK_DEBOUNCE_EN to debounce every coin channel.
module coin_bank #(
  parameter int                             NUM_COINS       = 4,
  parameter int                             TOTAL_W         = 8,
  parameter logic [NUM_COINS*TOTAL_W-1:0]   COIN_VALUES     = {8'd100, 8'd25, 8'd10, 8'd5},
  parameter int                             MAX_CREDIT      = 200,
  parameter int                             DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_COINS-1:0] coin_in,
  input  logic                 vend_valid,
  input  logic [TOTAL_W-1:0]   vend_price,
  input  logic                 refund,
  output logic [TOTAL_W-1:0]   credit,
  output logic [NUM_COINS-1:0] coin_reject,
  output logic                 vend_ack,
  output logic                 vend_ok,
  output logic                 change_valid,
  output logic [TOTAL_W-1:0]   change_amount
);

  localparam logic [TOTAL_W:0] MAX_CREDIT_W = (TOTAL_W+1)'(MAX_CREDIT);

  // An unusable parameter set is made visible in the hierarchy by this marker block.
  if (DEBOUNCE_CYCLES < 1 || MAX_CREDIT > (2**TOTAL_W) - 1) begin : g_invalid_parameters
  end

  logic [NUM_COINS-1:0] s0_q, s0_d;
  logic [NUM_COINS-1:0] s1_q, s1_d;
  logic [NUM_COINS-1:0] armed_q, armed_d;
  logic                 valid_q;
  logic [NUM_COINS-1:0] level;
  logic [NUM_COINS-1:0] pulse;

  logic [TOTAL_W-1:0]   credit_q, credit_d;
  logic [TOTAL_W-1:0]   change_q, change_d;
  logic [NUM_COINS-1:0] reject_q, reject_d;
  logic                 ack_q, ack_d;
  logic                 ok_q, ok_d;
  logic                 cv_q, cv_d;
  logic [TOTAL_W:0]     run_credit;

  // Per-channel qualified level: raw sync stage or debounced version of it.
  for (genvar gi = 0; gi < NUM_COINS; gi++) begin : g_chan
`ifdef COIN_BANK_DEBOUNCE_EN
    localparam int              DB     = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
    localparam int              CNT_W  = (DB > 1) ? $clog2(DB) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q counts earlier consecutive high samples; the current high sample completes the run.
    always_comb begin
      cnt_d = cnt_q;
      if (!s0_q[gi]) begin
        cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign level[gi] = s0_q[gi] && (cnt_q == CNT_MAX);
`else
    assign level[gi] = s0_q[gi];
`endif
  end

  // A channel only fires after its input has been seen low since reset, so a coin
  // held through reset never credits.
  always_comb begin
    s0_d    = coin_in;
    s1_d    = level;
    armed_d = armed_q | ({NUM_COINS{valid_q}} & ~s0_q);
  end

  assign pulse = level & ~s1_q & armed_q;

  always_comb begin
    credit_d   = credit_q;
    change_d   = change_q;
    reject_d   = '0;
    ack_d      = 1'b0;
    ok_d       = 1'b0;
    cv_d       = 1'b0;
    run_credit = {1'b0, credit_q};
    if (refund) begin
      change_d = credit_q;
      cv_d     = 1'b1;
      credit_d = '0;
      reject_d = pulse;
    end else begin
      if (vend_valid && !ack_q) begin
        ack_d = 1'b1;
        if (run_credit >= {1'b0, vend_price}) begin
          run_credit = run_credit - {1'b0, vend_price};
          ok_d       = 1'b1;
        end
      end
      // Lower channel indices claim remaining headroom first.
      for (int i = 0; i < NUM_COINS; i++) begin
        if (pulse[i]) begin
          if (run_credit + {1'b0, COIN_VALUES[i*TOTAL_W +: TOTAL_W]} <= MAX_CREDIT_W) begin
            run_credit = run_credit + {1'b0, COIN_VALUES[i*TOTAL_W +: TOTAL_W]};
          end else begin
            reject_d[i] = 1'b1;
          end
        end
      end
      credit_d = run_credit[TOTAL_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0_q     <= '0;
      s1_q     <= '0;
      armed_q  <= '0;
      valid_q  <= 1'b0;
      credit_q <= '0;
      change_q <= '0;
      reject_q <= '0;
      ack_q    <= 1'b0;
      ok_q     <= 1'b0;
      cv_q     <= 1'b0;
    end else begin
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      armed_q  <= armed_d;
      valid_q  <= 1'b1;
      credit_q <= credit_d;
      change_q <= change_d;
      reject_q <= reject_d;
      ack_q    <= ack_d;
      ok_q     <= ok_d;
      cv_q     <= cv_d;
    end
  end

  assign credit        = credit_q;
  assign coin_reject   = reject_q;
  assign vend_ack      = ack_q;
  assign vend_ok       = ok_q;
  assign change_valid  = cv_q;
  assign change_amount = change_q;

endmodule

// File: tb/tb_coin_bank.sv
// Directed bench for coin_bank: run-length coin model plus hand-computed pinned outputs.
module tb_coin_bank;
  localparam int NC   = 4;
  localparam int W    = 8;
  localparam int MAXC = 200;
  localparam int DB   = 4;
`ifdef COIN_BANK_DEBOUNCE_EN
  localparam int NEED = DB;
`else
  localparam int NEED = 1;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NC-1:0]  coin_in = '0;
  logic           vend_valid = 1'b0;
  logic [W-1:0]   vend_price = '0;
  logic           refund = 1'b0;
  logic [W-1:0]   credit;
  logic [NC-1:0]  coin_reject;
  logic           vend_ack;
  logic           vend_ok;
  logic           change_valid;
  logic [W-1:0]   change_amount;

  coin_bank #(
    .NUM_COINS(NC), .TOTAL_W(W), .COIN_VALUES({8'd100, 8'd25, 8'd10, 8'd5}),
    .MAX_CREDIT(MAXC), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .reset(reset), .coin_in(coin_in), .vend_valid(vend_valid),
    .vend_price(vend_price), .refund(refund), .credit(credit),
    .coin_reject(coin_reject), .vend_ack(vend_ack), .vend_ok(vend_ok),
    .change_valid(change_valid), .change_amount(change_amount)
  );

  always #5 clk = ~clk;

  // Model: outputs expected after each edge, from coin values and the channel run lengths.
  int        coin_val [NC] = '{5, 10, 25, 100};
  int        m_credit = 0, m_ca = 0;
  bit        m_ack = 0, m_ok = 0, m_cv = 0;
  bit [NC-1:0] m_rej = '0;
  int        run_len [NC] = '{0, 0, 0, 0};
  bit        seen_low [NC] = '{0, 0, 0, 0};
  bit [NC-1:0] ev;
  int        c;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_credit = 0; m_ca = 0; m_ack = 0; m_ok = 0; m_cv = 0; m_rej = '0;
        for (int i = 0; i < NC; i++) begin
          run_len[i] = 0; seen_low[i] = 0;
        end
      end else begin
        for (int i = 0; i < NC; i++) ev[i] = (run_len[i] == NEED) && seen_low[i];
        m_rej = '0; m_cv = 0; m_ok = 0;
        if (refund) begin
          m_ca = m_credit; m_cv = 1; m_credit = 0; m_rej = ev; m_ack = 0;
        end else begin
          c = m_credit;
          if (vend_valid && !m_ack) begin
            m_ack = 1;
            if (c >= int'(vend_price)) begin
              c = c - int'(vend_price); m_ok = 1;
            end
          end else begin
            m_ack = 0;
          end
          for (int i = 0; i < NC; i++) begin
            if (ev[i]) begin
              if (c + coin_val[i] <= MAXC) c = c + coin_val[i];
              else m_rej[i] = 1;
            end
          end
          m_credit = c;
        end
        for (int i = 0; i < NC; i++) begin
          if (coin_in[i]) begin
            if (run_len[i] < 1000) run_len[i] = run_len[i] + 1;
          end else begin
            run_len[i] = 0; seen_low[i] = 1;
          end
        end
      end
    end
  end

  // Pinned expectations, written by the stimulus and consumed by the compare process.
  int          pin_seq = 0, pin_done = 0;
  int          p_credit, p_ca;
  bit [NC-1:0] p_rej;
  bit          p_ack, p_ok, p_cv;
  int          n_vec = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("credit", 16'(credit), 16'(m_credit));
      chk("coin_reject", 16'(coin_reject), 16'(m_rej));
      chk("vend_ack", 16'(vend_ack), 16'(m_ack));
      if (m_ack) chk("vend_ok", 16'(vend_ok), 16'(m_ok));
      chk("change_valid", 16'(change_valid), 16'(m_cv));
      chk("change_amount", 16'(change_amount), 16'(m_ca));
      if (pin_seq != pin_done) begin
        chk("pin_model_credit", 16'(m_credit), 16'(p_credit));
        chk("pin_model_reject", 16'(m_rej), 16'(p_rej));
        chk("pin_model_ack", 16'(m_ack), 16'(p_ack));
        chk("pin_model_ok", 16'(m_ok), 16'(p_ok));
        chk("pin_model_cv", 16'(m_cv), 16'(p_cv));
        chk("pin_model_ca", 16'(m_ca), 16'(p_ca));
        chk("pin_dut_credit", 16'(credit), 16'(p_credit));
        chk("pin_dut_reject", 16'(coin_reject), 16'(p_rej));
        chk("pin_dut_ack_ok", 16'({vend_ack, vend_ok}), 16'({p_ack, p_ok}));
        chk("pin_dut_change", 16'({change_valid, change_amount}), 16'({p_cv, 8'(p_ca)}));
        $display("pin #%0d t=%0t credit=%0d reject=%b ack=%0b ok=%0b cv=%0b ca=%0d",
                 pin_seq, $time, credit, coin_reject, vend_ack, vend_ok, change_valid, change_amount);
        pin_done = pin_seq;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pin(input int cr, input bit [NC-1:0] rj, input bit ak, input bit ok,
                     input bit cv, input int ca);
    p_credit = cr; p_rej = rj; p_ack = ak; p_ok = ok; p_cv = cv; p_ca = ca;
    pin_seq++;
  endtask

  task automatic ins(input int ch);
    coin_in[ch] = 1'b1;
    repeat (NEED) step();
    coin_in[ch] = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) step();
    pin(0, 4'b0000, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    repeat (3) step();

    // Single held coin credits once
    coin_in[2] = 1'b1;
    repeat (NEED) step();
    pin(25, 4'b0000, 0, 0, 0, 0);
    repeat (6 - NEED) step();
    pin(25, 4'b0000, 0, 0, 0, 0);
    step();
    coin_in = '0;
    repeat (2) step();

    // Ceiling reject at 190, then exact fill to 200
    ins(3); ins(2); ins(2); ins(1); ins(0);
    coin_in[2] = 1'b1;
    repeat (NEED) step();
    pin(190, 4'b0100, 0, 0, 0, 0);
    step();
    coin_in = '0;
    repeat (2) step();
    ins(1);
    pin(200, 4'b0000, 0, 0, 0, 0);
    step();

    refund = 1'b1;
    pin(0, 4'b0000, 0, 0, 1, 200);
    step();
    refund = 1'b0;
    step();

    // Simultaneous coins from 170
    ins(3); ins(2); ins(2); ins(1); ins(1);
    coin_in = 4'b0111;
    repeat (NEED) step();
    pin(185, 4'b0100, 0, 0, 0, 200);
    step();
    coin_in = '0;
    repeat (2) step();

    // Vend handshake
    refund = 1'b1;
    pin(0, 4'b0000, 0, 0, 1, 185);
    step();
    refund = 1'b0;
    step();
    ins(2); ins(2); ins(1);
    vend_price = 8'd65; vend_valid = 1'b1;
    pin(60, 4'b0000, 1, 0, 0, 185);
    step();
    vend_valid = 1'b0;
    step();
    ins(0);
    vend_valid = 1'b1;
    pin(0, 4'b0000, 1, 1, 0, 185);
    step();
    pin(0, 4'b0000, 0, 0, 0, 185);
    step();
    vend_valid = 1'b0;
    step();

    // Zero price always succeeds
    vend_price = 8'd0; vend_valid = 1'b1;
    pin(0, 4'b0000, 1, 1, 0, 185);
    step();
    vend_valid = 1'b0;
    step();

    // Refund collides with a coin and a vend
    ins(3); ins(2); ins(1);
    coin_in[1] = 1'b1;
    repeat (NEED) step();
    refund = 1'b1; vend_valid = 1'b1; vend_price = 8'd10; coin_in = '0;
    pin(0, 4'b0010, 0, 0, 1, 135);
    step();
    refund = 1'b0;
    pin(0, 4'b0000, 1, 0, 0, 135);
    step();
    vend_valid = 1'b0;
    step();

    // Vend and coin together: deduct before add
    ins(3); ins(3);
    coin_in[2] = 1'b1;
    repeat (NEED) step();
    vend_valid = 1'b1; vend_price = 8'd50; coin_in = '0;
    pin(175, 4'b0000, 1, 1, 0, 135);
    step();
    vend_valid = 1'b0;
    step();

    // Reset mid-coin and mid-handshake; held coin must not credit afterwards
    coin_in[3] = 1'b1;
    step();
    reset = 1'b1; vend_valid = 1'b1; vend_price = 8'd5;
    step();
    pin(0, 4'b0000, 0, 0, 0, 0);
    step();
    reset = 1'b0; vend_valid = 1'b0;
    repeat (8) step();
    pin(0, 4'b0000, 0, 0, 0, 0);
    step();
    coin_in = '0;
    repeat (2) step();
    coin_in[3] = 1'b1;
    repeat (NEED) step();
    pin(100, 4'b0000, 0, 0, 0, 0);
    step();
    coin_in = '0;
    repeat (2) step();

`ifdef COIN_BANK_DEBOUNCE_EN
    // Short glitch is filtered
    coin_in[0] = 1'b1;
    repeat (3) step();
    coin_in = '0;
    repeat (4) step();
    pin(100, 4'b0000, 0, 0, 0, 0);
    step();
`endif

    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/coin_bank.md
# coin_bank

Parametrised credit accumulator for the vending datapath. It sits between the coin-slot inputs and the vend controller. It converts N coin-slot levels into one-shot credit increments, holds credit against a hard ceiling, and rejects coins that would exceed that ceiling. It also serves vend deductions through a valid/ack handshake and returns change on refund.

## Interface
- NUM_COINS, 4: number of coin channels.
- TOTAL_W, 8: credit/price/change width.
- COIN_VALUES, {8'd100, 8'd25, 8'd10, 8'd5}: packed NUM_COINS×TOTAL_W values; channel i uses bits [i*TOTAL_W +: TOTAL_W].
- MAX_CREDIT, 200: credit ceiling; must be ≤ 2^TOTAL_W−1.
- DEBOUNCE_CYCLES, 4: stable-high samples needed to qualify a coin (debounce build only); must be ≥ 1.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- coin_in  in  NUM_COINS  raw coin-slot levels; a rising edge (after qualification) is one coin.
- vend_valid  in  1  vend request, held until vend_ack.
- vend_price  in  TOTAL_W  price; stable while vend_valid is high.
- refund  in  1  single-cycle refund request.
- credit  out  TOTAL_W  current credit (registered).
- coin_reject  out  NUM_COINS  one-cycle pulse per refused coin.
- vend_ack  out  1  one-cycle response pulse.
- vend_ok  out  1  valid with vend_ack: 1 means deducted, 0 means insufficient credit.
- change_valid  out  1  one-cycle pulse.
- change_amount  out  TOTAL_W  refunded amount; holds until the next refund.

## Operation
- Reset drives credit, coin_reject, vend_ack, vend_ok, change_valid, change_amount, sync registers and debounce counters to 0.
- Per channel, coin_in is registered (s0, then s1). The pulse is s0 & ~s1, so a held level yields exactly one pulse.
- Each update cycle is evaluated in this priority order:
  1. **refund.** change_amount ← credit, change_valid=1, credit ← 0. Any coin pulse in the same cycle is rejected. A pending vend_valid is not acked that cycle and is evaluated next cycle against 0 credit.
  2. **vend.** Only when vend_valid=1 and vend_ack=0. If credit ≥ vend_price: credit −= vend_price and vend_ok=1. Otherwise credit is unchanged and vend_ok=0. vend_ack=1 in both cases. vend_price=0 always succeeds.
  3. **coins.** Starting from the post-vend credit, walk channels from index 0 upward. Channel i is accepted if running + COIN_VALUES[i] ≤ MAX_CREDIT; otherwise coin_reject[i]=1 and its value is dropped.
- All arithmetic is done at TOTAL_W+1 bits. credit never exceeds MAX_CREDIT and never wraps.
- A requester must drop vend_valid in the cycle vend_ack is high. Because the block ignores vend_valid while vend_ack=1, one request gives exactly one deduction.

## Timing
- Coin, non-debounce build: coin_in high before edge k → s0 at k → pulse in cycle k..k+1 → credit/coin_reject updated at edge k+1. Latency is 2 edges.
- Coin, debounce build: latency is DEBOUNCE_CYCLES+1 edges from the first high sample.
- Vend: vend_valid sampled high at edge k → vend_ack/vend_ok/credit all registered at edge k. These are visible in the cycle after k, with 1-cycle latency.
- Refund: sampled at edge k → change_valid/change_amount/credit=0 at edge k.
- A coin pulse and a vend in the same cycle both apply: deduct first, then add.
- Reset asserted mid-debounce or mid-handshake aborts everything. No pulse, credit or ack escapes after reset deasserts.

## Configuration
- COIN_BANK_DEBOUNCE_EN defined: each channel has a counter. The qualified level rises after DEBOUNCE_CYCLES consecutive high samples of s0. It falls on the first low sample, and the counter clears. The pulse is the rising edge of the qualified level. Glitches shorter than DEBOUNCE_CYCLES produce no credit.
- COIN_BANK_DEBOUNCE_EN undefined: plain two-register edge detect, and DEBOUNCE_CYCLES is unused.

## Test plan
- **Single held coin.** coin_in[2] high for 6 cycles, credit 0 → credit=25 exactly once, no coin_reject.
- **Ceiling reject.** Credit 190, then coin_in[2] → coin_reject[2] pulse, credit stays 190. Then coin_in[1] → credit=200.
- **Simultaneous coins.** Credit 170, coin_in[2:0] rise together → credit=185, coin_reject=4'b0100.
- **Vend handshake.** Credit 60, vend_price=65 → vend_ack=1, vend_ok=0, credit 60. Then insert 5 and vend 65 → vend_ok=1, credit 0. Holding vend_valid one extra cycle must not produce a second ack.
- **Refund collision.** Credit 135; refund, coin_in[1] edge and vend_valid (price 10) all land in the same cycle → change_amount=135, change_valid pulse, credit 0, coin_reject[1]=1. Next cycle: vend_ack=1, vend_ok=0.
- **Reset/debounce.** With COIN_BANK_DEBOUNCE_EN, a 3-cycle coin glitch gives no credit. Reset asserted mid-debounce of a 10-cycle coin gives credit 0, and no pulse after release unless the input goes low and then high again.
